riscv_retire_monitor: RTL and testbench
=======================================

// Module: riscv_retire_monitor
// PURPOSE
//  Core-side producer of the CPU status outputs NUM_INST, OUTPUT_PORT and HALT
//  that the system testbench samples every posedge CLK. It sits inside
//  RISCV_TOP and watches each retiring instruction: counts retirements,
//  latches one observable result per instruction and detects the halt pair.
//  All outputs are registered, so single- and multi-cycle datapaths both work
//  off a single retire strobe.
// PARAMETERS
//  CNT_W      32            width of NUM_INST counter
//  HALT_W0    32'h00c00093  first word of halt sequence (addi x1,x0,12)
//  HALT_W1    32'h00008067  second word of halt sequence (jalr x0,0(x1))
// PORTS
//  CLK          in   1       core clock, all state on posedge
//  RSTn         in   1       asynchronous active-low reset
//  RETIRE       in   1       one-cycle strobe: INST completes this cycle
//  INST         in   32      instruction word being retired
//  RF_WE        in   1       retiring instruction writes the register file
//  RF_WA        in   5       destination register of that write
//  RF_WD        in   32      data written to register file
//  ST_ADDR      in   12      D-memory byte address of a retiring store
//  BR_TAKEN     in   1       retiring branch resolved taken
//  NUM_INST     out  CNT_W   count of retired, non-halt-terminating insts
//  OUTPUT_PORT  out  32      observable result of last counted instruction
//  HALT         out  1       sticky; high once halt pair has retired
// BEHAVIOUR
//  - Reset (async, RSTn=0): NUM_INST=0, OUTPUT_PORT=0, HALT=0, FSM=IDLE;
//    release is synchronous to next posedge, first count on that edge.
//  - Only edges with RETIRE=1 and HALT=0 change state; RETIRE=0 holds all.
//  - Latency: effects of a retirement visible on outputs the cycle after the
//    RETIRE edge (register output, no combinational path in->out).
//  - OUTPUT_PORT select, priority order, on a counted retirement:
//    1 opcode STORE (0100011): {20'b0, ST_ADDR}
//    2 opcode BRANCH (1100011): {31'b0, BR_TAKEN}
//    3 RF_WE=1 and RF_WA!=0: RF_WD
//    4 otherwise (writes to x0, fence, etc.): hold previous value
//  - NUM_INST += 1 per counted retirement, modulo 2^CNT_W (wraps, no flag).
//  - Halt FSM (evaluated on RETIRE edges only):
//    IDLE  : INST==HALT_W0 -> ARMED (inst counted normally, result latched)
//            else stay IDLE
//    ARMED : INST==HALT_W1 -> DONE (NOT counted, OUTPUT_PORT held, HALT<=1)
//            INST==HALT_W0 -> stay ARMED (counted)
//            else          -> IDLE (counted)
//    DONE  : terminal until reset; all inputs ignored, outputs frozen.
//  - HALT_W1 retired while IDLE is an ordinary jalr: counted, no halt.
//  - Reset asserted mid-stream (any state, incl. DONE) clears everything
//    immediately; no partial-update window.
//  - RETIRE on consecutive cycles is legal; each edge is one instruction.
// STRUCTURE
//  - Shared package riscv_pkg: OPC_STORE, OPC_BRANCH 7-bit opcode constants,
//    HALT_WORD0/HALT_WORD1, typedef/localparams for FSM encoding
//    (IDLE=2'd0, ARMED=2'd1, DONE=2'd2; 2'd3 unreachable, decodes as IDLE).
//  - One natural sub-module: riscv_halt_det (3-state FSM; inputs RETIRE,
//    INST; outputs count_en, halt). Counter and output mux stay in top.
// TESTING
//  - Reset: RSTn=0 async mid-cycle -> NUM_INST=0, OUTPUT_PORT=0, HALT=0 at
//    once, before any edge.
//  - addi x5,x0,5 retired (RF_WE=1,RF_WA=5,RF_WD=5) -> next cycle
//    NUM_INST=1, OUTPUT_PORT=0x5; then 3 idle cycles -> values held.
//  - sw with ST_ADDR=12'h010 then beq taken -> OUTPUT_PORT 0x10 then 0x1;
//    NUM_INST +1 each; write to x0 (RF_WA=0,RF_WD=7) -> count+1, port held.
//  - Halt: retire 0x00c00093 then 0x00008067 back-to-back from NUM_INST=26
//    -> NUM_INST=27, OUTPUT_PORT=0xC, HALT=1; further RETIRE ignored.
//  - False halt: 0x00c00093, addi, 0x00008067 -> HALT stays 0, count +3.
//  - Wrap: CNT_W=4, 16 retirements -> NUM_INST returns to 0; reset while
//    HALT=1 -> HALT=0 and counting resumes from 0.

Source files
------------

// File: rtl/riscv_retire_monitor_pkg.sv
// Shared constants and types for the retire monitor: opcodes, halt-sequence
// words and the halt detector state encoding.
package riscv_pkg;

    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

    // addi x1,x0,12 followed by jalr x0,0(x1) terminates a program
    localparam logic [31:0] HALT_WORD0 = 32'h00c00093;
    localparam logic [31:0] HALT_WORD1 = 32'h00008067;

    // Encoding 2'd3 is never entered; the detector treats it like IDLE
    typedef enum logic [1:0] {
        HS_IDLE  = 2'd0,
        HS_ARMED = 2'd1,
        HS_DONE  = 2'd2
    } halt_state_e;

    function automatic logic [6:0] opcode_of(input logic [31:0] inst);
        return inst[6:0];
    endfunction

endpackage

// File: rtl/riscv_retire_monitor_if.sv
// Retirement bus from the core datapath to the retire monitor.
interface riscv_retire_monitor_if;

    logic        RETIRE;
    logic [31:0] INST;
    logic        RF_WE;
    logic [4:0]  RF_WA;
    logic [31:0] RF_WD;
    logic [11:0] ST_ADDR;
    logic        BR_TAKEN;

    // Datapath side drives the retiring instruction's information
    modport master (
        output RETIRE, INST, RF_WE, RF_WA, RF_WD, ST_ADDR, BR_TAKEN
    );

    // Monitor side only observes
    modport slave (
        input RETIRE, INST, RF_WE, RF_WA, RF_WD, ST_ADDR, BR_TAKEN
    );

endinterface

// File: rtl/riscv_halt_det.sv
// Halt-pair detector: tracks the two-word halt sequence across retirements,
// tells the top whether the current retirement is counted, and flags halt.
module riscv_halt_det
    import riscv_pkg::*;
#(
    parameter logic [31:0] HALT_W0 = HALT_WORD0,
    parameter logic [31:0] HALT_W1 = HALT_WORD1
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        retire_i,
    input  logic [31:0] inst_i,
    output logic        count_en_o,
    output logic        halt_o
);

    halt_state_e state_q;
    halt_state_e state_d;

    // State register; reset returns to IDLE immediately
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= HS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and count enable; the terminating jalr is never counted
    always_comb begin
        state_d    = state_q;
        count_en_o = 1'b0;
        halt_o     = 1'b0;
        case (state_q)
            HS_ARMED: begin
                if (retire_i) begin
                    if (inst_i == HALT_W1) begin
                        state_d = HS_DONE;
                    end else begin
                        count_en_o = 1'b1;
                        state_d    = (inst_i == HALT_W0) ? HS_ARMED : HS_IDLE;
                    end
                end
            end
            HS_DONE: begin
                halt_o = 1'b1;
            end
            default: begin
                // IDLE, and the unused encoding behaves the same way
                if (retire_i) begin
                    count_en_o = 1'b1;
                    state_d    = (inst_i == HALT_W0) ? HS_ARMED : HS_IDLE;
                end
            end
        endcase
    end

endmodule

// File: rtl/riscv_retire_monitor.sv
// Retire monitor: counts retired instructions, latches one observable result
// per instruction and raises a sticky HALT once the halt pair retires.
// All outputs come straight from registers.
module riscv_retire_monitor
    import riscv_pkg::*;
#(
    parameter int          CNT_W   = 32,
    parameter logic [31:0] HALT_W0 = HALT_WORD0,
    parameter logic [31:0] HALT_W1 = HALT_WORD1
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    riscv_retire_monitor_if.slave ret,
    output logic [CNT_W-1:0]     NUM_INST,
    output logic [31:0]          OUTPUT_PORT,
    output logic                 HALT
);

    logic             count_en;
    logic             halt_det;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [31:0]      port_q;
    logic [31:0]      port_d;
    logic [6:0]       opcode;

    riscv_halt_det #(
        .HALT_W0 (HALT_W0),
        .HALT_W1 (HALT_W1)
    ) u_halt_det (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .retire_i   (ret.RETIRE),
        .inst_i     (ret.INST),
        .count_en_o (count_en),
        .halt_o     (halt_det)
    );

    assign opcode = opcode_of(ret.INST);

    // Count and result select for a counted retirement; stores win over
    // branches, which win over register writes; x0 writes leave the port alone
    always_comb begin
        count_d = count_q;
        port_d  = port_q;
        if (count_en) begin
            count_d = count_q + CNT_W'(1);
            if (opcode == OPC_STORE) begin
                port_d = {20'b0, ret.ST_ADDR};
            end else if (opcode == OPC_BRANCH) begin
                port_d = {31'b0, ret.BR_TAKEN};
            end else if (ret.RF_WE && (ret.RF_WA != 5'd0)) begin
                port_d = ret.RF_WD;
            end
        end
    end

    // Output registers; counter wraps silently
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            count_q <= '0;
            port_q  <= '0;
        end else begin
            count_q <= count_d;
            port_q  <= port_d;
        end
    end

    assign NUM_INST    = count_q;
    assign OUTPUT_PORT = port_q;
    assign HALT        = halt_det;

endmodule

// File: tb/tb_riscv_retire_monitor.sv
// Directed bench for riscv_retire_monitor: a 32-bit counter instance for the
// main flow and halt detection, and a 4-bit counter instance for wrap-around.
module tb_riscv_retire_monitor;

    logic CLK;
    logic RSTn;

    riscv_retire_monitor_if if_a ();
    riscv_retire_monitor_if if_b ();

    logic [31:0] num_a;
    logic [31:0] port_a;
    logic        halt_a;
    logic [3:0]  num_b;
    logic [31:0] port_b;
    logic        halt_b;

    int checks;
    int errors;

    riscv_retire_monitor #(.CNT_W(32)) dut_a (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .ret         (if_a.slave),
        .NUM_INST    (num_a),
        .OUTPUT_PORT (port_a),
        .HALT        (halt_a)
    );

    riscv_retire_monitor #(.CNT_W(4)) dut_b (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .ret         (if_b.slave),
        .NUM_INST    (num_b),
        .OUTPUT_PORT (port_b),
        .HALT        (halt_b)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    // One retirement on instance A (sel=0) or B (sel=1); returns 1ns after the edge
    task automatic retire(input bit sel, input logic [31:0] inst, input logic we,
                          input logic [4:0] wa, input logic [31:0] wd,
                          input logic [11:0] st, input logic br);
        if (!sel) begin
            if_a.RETIRE = 1'b1; if_a.INST = inst; if_a.RF_WE = we; if_a.RF_WA = wa;
            if_a.RF_WD = wd; if_a.ST_ADDR = st; if_a.BR_TAKEN = br;
        end else begin
            if_b.RETIRE = 1'b1; if_b.INST = inst; if_b.RF_WE = we; if_b.RF_WA = wa;
            if_b.RF_WD = wd; if_b.ST_ADDR = st; if_b.BR_TAKEN = br;
        end
        @(posedge CLK);
        #1;
        if_a.RETIRE = 1'b0;
        if_b.RETIRE = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RSTn = 1'b1;
        if_a.RETIRE = 1'b0; if_a.INST = '0; if_a.RF_WE = 1'b0; if_a.RF_WA = '0;
        if_a.RF_WD = '0; if_a.ST_ADDR = '0; if_a.BR_TAKEN = 1'b0;
        if_b.RETIRE = 1'b0; if_b.INST = '0; if_b.RF_WE = 1'b0; if_b.RF_WA = '0;
        if_b.RF_WD = '0; if_b.ST_ADDR = '0; if_b.BR_TAKEN = 1'b0;

        // Asynchronous reset before any clock edge
        #2 RSTn = 1'b0;
        #1;
        check("rst_num", num_a, 32'd0);
        check("rst_port", port_a, 32'd0);
        check("rst_halt", {31'b0, halt_a}, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;

        // addi x5,x0,5
        retire(0, 32'h00500293, 1'b1, 5'd5, 32'd5, 12'h000, 1'b0);
        check("addi_num", num_a, 32'd1);
        check("addi_port", port_a, 32'h5);
        idle(3);
        check("hold_num", num_a, 32'd1);
        check("hold_port", port_a, 32'h5);

        // sw: store address wins even with a register write present
        retire(0, 32'h0050a823, 1'b1, 5'd3, 32'hdead_beef, 12'h010, 1'b0);
        check("sw_num", num_a, 32'd2);
        check("sw_port", port_a, 32'h10);
        // beq taken
        retire(0, 32'h00000463, 1'b0, 5'd0, 32'd0, 12'h000, 1'b1);
        check("beq_num", num_a, 32'd3);
        check("beq_port", port_a, 32'h1);
        // addi x0,x0,7: counted, port held
        retire(0, 32'h00700013, 1'b1, 5'd0, 32'd7, 12'h000, 1'b0);
        check("x0_num", num_a, 32'd4);
        check("x0_port", port_a, 32'h1);

        // False halt: W0, addi x2, W1 -> all counted, no halt
        retire(0, 32'h00c00093, 1'b1, 5'd1, 32'hC, 12'h000, 1'b0);
        retire(0, 32'h00300113, 1'b1, 5'd2, 32'h3, 12'h000, 1'b0);
        retire(0, 32'h00008067, 1'b0, 5'd0, 32'd0, 12'h000, 1'b0);
        check("fh_num", num_a, 32'd7);
        check("fh_port", port_a, 32'h3);
        check("fh_halt", {31'b0, halt_a}, 32'd0);

        // Lone W1 while idle is an ordinary jalr
        retire(0, 32'h00008067, 1'b0, 5'd0, 32'd0, 12'h000, 1'b0);
        check("jalr_num", num_a, 32'd8);
        check("jalr_halt", {31'b0, halt_a}, 32'd0);

        // Bring count to 26 with nops
        for (int i = 0; i < 18; i++) begin
            retire(0, 32'h00000013, 1'b1, 5'd0, 32'd0, 12'h000, 1'b0);
        end
        check("pre_num", num_a, 32'd26);

        // Halt pair back-to-back
        retire(0, 32'h00c00093, 1'b1, 5'd1, 32'hC, 12'h000, 1'b0);
        check("w0_num", num_a, 32'd27);
        check("w0_halt", {31'b0, halt_a}, 32'd0);
        retire(0, 32'h00008067, 1'b0, 5'd0, 32'd0, 12'h000, 1'b0);
        check("halt_num", num_a, 32'd27);
        check("halt_port", port_a, 32'hC);
        check("halt_flag", {31'b0, halt_a}, 32'd1);

        // Retirements after halt are ignored
        retire(0, 32'h06300293, 1'b1, 5'd5, 32'd99, 12'h000, 1'b0);
        retire(0, 32'h0050a823, 1'b0, 5'd0, 32'd0, 12'h0ff, 1'b0);
        check("post_num", num_a, 32'd27);
        check("post_port", port_a, 32'hC);
        check("post_halt", {31'b0, halt_a}, 32'd1);

        // Reset mid-cycle while halted clears at once
        @(posedge CLK);
        #3 RSTn = 1'b0;
        #1;
        check("rst2_num", num_a, 32'd0);
        check("rst2_port", port_a, 32'd0);
        check("rst2_halt", {31'b0, halt_a}, 32'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        retire(0, 32'h00500293, 1'b1, 5'd5, 32'd42, 12'h000, 1'b0);
        check("resume_num", num_a, 32'd1);
        check("resume_port", port_a, 32'd42);
        check("resume_halt", {31'b0, halt_a}, 32'd0);

        // Repeated W0 keeps the detector armed, then W1 halts
        retire(0, 32'h00c00093, 1'b1, 5'd1, 32'hC, 12'h000, 1'b0);
        retire(0, 32'h00c00093, 1'b1, 5'd1, 32'hC, 12'h000, 1'b0);
        retire(0, 32'h00008067, 1'b0, 5'd0, 32'd0, 12'h000, 1'b0);
        check("w0w0_num", num_a, 32'd3);
        check("w0w0_halt", {31'b0, halt_a}, 32'd1);

        // 4-bit counter instance (reset above cleared it too): wraps after 16
        for (int i = 0; i < 15; i++) begin
            retire(1, 32'h00000013, 1'b0, 5'd0, 32'd0, 12'h000, 1'b0);
        end
        check("wrap_15", {28'b0, num_b}, 32'd15);
        retire(1, 32'h00000013, 1'b0, 5'd0, 32'd0, 12'h000, 1'b0);
        check("wrap_0", {28'b0, num_b}, 32'd0);
        check("wrap_halt", {31'b0, halt_b}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
